// File: rtl/pipe_pkg.sv
// Shared constants, header struct and tnew ageing helper for the elastic
// pipeline-stage register.
package pipe_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          TNEW_W_DEF   = 5;
  localparam int          TNEW_MAX_W   = 16;

  // Fixed-width part of a stage payload; data and tnew widths follow the
  // instantiating module's parameters.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  wa;
    logic        we;
  } pipe_hdr_t;

  function automatic logic [TNEW_MAX_W-1:0] tnew_age(input logic [TNEW_MAX_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus payload, with load/clear controls.
// Clear takes priority over load; reset returns the entry to the cleared state.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = TNEW_W_DEF,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [4:0]        i_wa,
  input  logic              i_we,
  input  logic [TNEW_W-1:0] i_tnew,
  output logic              o_valid,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_instr,
  output logic [DATA_W-1:0] o_data,
  output logic [4:0]        o_wa,
  output logic              o_we,
  output logic [TNEW_W-1:0] o_tnew
);

  logic              r_valid;
  pipe_hdr_t         r_hdr;
  logic [DATA_W-1:0] r_data;
  logic [TNEW_W-1:0] r_tnew;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_clear) begin
      r_valid     <= 1'b0;
      r_hdr.pc    <= PC_RESET;
      r_hdr.instr <= '0;
      r_hdr.wa    <= '0;
      r_hdr.we    <= 1'b0;
      r_data      <= '0;
      r_tnew      <= '0;
    end else if (i_load) begin
      r_valid     <= 1'b1;
      r_hdr.pc    <= i_pc;
      r_hdr.instr <= i_instr;
      r_hdr.wa    <= i_wa;
      r_hdr.we    <= i_we;
      r_data      <= i_data;
      r_tnew      <= i_tnew;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_hdr.pc;
  assign o_instr = r_hdr.instr;
  assign o_wa    = r_hdr.wa;
  assign o_we    = r_hdr.we;
  assign o_data  = r_data;
  assign o_tnew  = r_tnew;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic stage register between two MIPS pipeline stages: valid/ready
// handshake, flush-to-bubble, optional skid entry, and tnew ageing on capture.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 64,
  parameter int          TNEW_W   = TNEW_W_DEF,
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter bit          SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_wa,
  input  logic              in_we,
  input  logic [TNEW_W-1:0] in_tnew,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_wa,
  output logic              out_we,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              busy
);

  logic              w_in_fire, w_out_fire;
  logic [TNEW_W-1:0] w_tnew_aged;
  logic              w_m_load, w_m_clear, w_m_src_s;
  logic [31:0]       w_m_pc, w_m_instr;
  logic [DATA_W-1:0] w_m_data;
  logic [4:0]        w_m_wa;
  logic              w_m_we;
  logic [TNEW_W-1:0] w_m_tnew;
  logic              w_s_valid;
  logic [31:0]       w_s_pc, w_s_instr;
  logic [DATA_W-1:0] w_s_data;
  logic [4:0]        w_s_wa;
  logic              w_s_we;
  logic [TNEW_W-1:0] w_s_tnew;

  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = out_valid & out_ready;
  assign w_tnew_aged = TNEW_W'(tnew_age(TNEW_MAX_W'(in_tnew)));

  // A beat moving from S into M was aged when S captured it.
  assign w_m_pc    = w_m_src_s ? w_s_pc    : in_pc;
  assign w_m_instr = w_m_src_s ? w_s_instr : in_instr;
  assign w_m_data  = w_m_src_s ? w_s_data  : in_data;
  assign w_m_wa    = w_m_src_s ? w_s_wa    : in_wa;
  assign w_m_we    = w_m_src_s ? w_s_we    : in_we;
  assign w_m_tnew  = w_m_src_s ? w_s_tnew  : w_tnew_aged;

  generate
    if (SKID) begin : g_skid
      logic w_m_take, w_s_load, w_s_clear;

      assign w_m_take  = ~out_valid | w_out_fire;
      assign w_m_src_s = w_s_valid;
      assign w_m_load  = w_m_take & (w_s_valid | w_in_fire);
      assign w_m_clear = flush | (w_m_take & ~w_s_valid & ~w_in_fire);
      // in_ready is low whenever S is valid, so S never refills while draining.
      assign w_s_load  = ~w_m_take & w_in_fire;
      assign w_s_clear = flush | (w_m_take & w_s_valid);
      assign in_ready  = ~w_s_valid;
      assign busy      = w_s_valid;

      pipe_slot #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .PC_RESET(PC_RESET)) u_s (
        .clk(clk), .rst(reset), .i_load(w_s_load), .i_clear(w_s_clear),
        .i_pc(in_pc), .i_instr(in_instr), .i_data(in_data), .i_wa(in_wa),
        .i_we(in_we), .i_tnew(w_tnew_aged),
        .o_valid(w_s_valid), .o_pc(w_s_pc), .o_instr(w_s_instr), .o_data(w_s_data),
        .o_wa(w_s_wa), .o_we(w_s_we), .o_tnew(w_s_tnew)
      );
    end else begin : g_noskid
      assign w_m_src_s = 1'b0;
      assign w_m_load  = w_in_fire;
      assign w_m_clear = flush | (w_out_fire & ~w_in_fire);
      assign in_ready  = ~out_valid | out_ready;
      assign busy      = 1'b0;
      assign w_s_valid = 1'b0;
      assign w_s_pc    = PC_RESET;
      assign w_s_instr = '0;
      assign w_s_data  = '0;
      assign w_s_wa    = '0;
      assign w_s_we    = 1'b0;
      assign w_s_tnew  = '0;
    end
  endgenerate

  pipe_slot #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .PC_RESET(PC_RESET)) u_m (
    .clk(clk), .rst(reset), .i_load(w_m_load), .i_clear(w_m_clear),
    .i_pc(w_m_pc), .i_instr(w_m_instr), .i_data(w_m_data), .i_wa(w_m_wa),
    .i_we(w_m_we), .i_tnew(w_m_tnew),
    .o_valid(out_valid), .o_pc(out_pc), .o_instr(out_instr), .o_data(out_data),
    .o_wa(out_wa), .o_we(out_we), .o_tnew(out_tnew)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share
// the upstream stimulus; each has its own out_ready.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_we;
  logic [31:0] in_pc, in_instr;
  logic [63:0] in_data;
  logic [4:0]  in_wa, in_tnew;
  logic        ordy1, ordy0;

  logic        in_ready1, out_valid1, out_we1, busy1;
  logic [31:0] out_pc1, out_instr1;
  logic [63:0] out_data1;
  logic [4:0]  out_wa1, out_tnew1;
  logic        in_ready0, out_valid0, out_we0, busy0;
  logic [31:0] out_pc0, out_instr0;
  logic [63:0] out_data0;
  logic [4:0]  out_wa0, out_tnew0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_wa(in_wa), .in_we(in_we),
    .in_tnew(in_tnew), .out_valid(out_valid1), .out_ready(ordy1), .out_pc(out_pc1),
    .out_instr(out_instr1), .out_data(out_data1), .out_wa(out_wa1), .out_we(out_we1),
    .out_tnew(out_tnew1), .busy(busy1)
  );

  pipe_stage_reg #(.SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data), .in_wa(in_wa), .in_we(in_we),
    .in_tnew(in_tnew), .out_valid(out_valid0), .out_ready(ordy0), .out_pc(out_pc0),
    .out_instr(out_instr0), .out_data(out_data0), .out_wa(out_wa0), .out_we(out_we0),
    .out_tnew(out_tnew0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic v, input logic [31:0] pc, input logic [4:0] tn,
                     input logic we, input logic [4:0] wa);
    in_valid = v;
    in_pc    = pc;
    in_instr = ~pc;
    in_data  = {pc, ~pc};
    in_tnew  = tn;
    in_we    = we;
    in_wa    = wa;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ordy1 = 1'b1; ordy0 = 1'b1;
    put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
    step; step;
    chk("rst_valid", out_valid1, 0);
    chk("rst_pc", out_pc1, 64'h3000);
    chk("rst_we", out_we1, 0);
    chk("rst_tnew", out_tnew1, 0);
    chk("rst_rdy1", in_ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_rdy0", in_ready0, 1);
    reset = 1'b0;

    // streaming, SKID=1, out_ready high
    for (int k = 0; k < 4; k++) begin
      put(1'b1, 32'h3000 + 32'(4 * k), (k == 3) ? 5'd0 : 5'd2, 1'b0, 5'd0);
      step;
      chk($sformatf("str%0d_valid", k), out_valid1, 1);
      chk($sformatf("str%0d_pc", k), out_pc1, 64'h3000 + 64'(4 * k));
      chk($sformatf("str%0d_tnew", k), out_tnew1, (k == 3) ? 64'd0 : 64'd1);
    end
    chk("str_instr", out_instr1, 64'hFFFF_CFF3);
    chk("str_data", out_data1, 64'h0000_300C_FFFF_CFF3);

    // asynchronous reset mid-stream
    put(1'b1, 32'h3010, 5'd2, 1'b1, 5'd3);
    step;
    chk("mid_pc_before", out_pc1, 64'h3010);
    reset = 1'b1;
    #1;
    chk("mid_valid", out_valid1, 0);
    chk("mid_pc", out_pc1, 64'h3000);
    chk("mid_we", out_we1, 0);
    chk("mid_rdy", in_ready1, 1);
    chk("mid_busy", busy1, 0);
    step;
    reset = 1'b0;

    // bubble after a lone beat
    put(1'b1, 32'h3020, 5'd3, 1'b1, 5'd8);
    step;
    chk("bub_we1", out_we1, 1);
    chk("bub_wa8", out_wa1, 8);
    chk("bub_tnew", out_tnew1, 2);
    put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
    step;
    chk("bub_valid", out_valid1, 0);
    chk("bub_we0", out_we1, 0);
    chk("bub_wa0", out_wa1, 0);
    chk("bub_pc", out_pc1, 64'h3000);

    // backpressure into the skid entry
    put(1'b1, 32'h100, 5'd1, 1'b0, 5'd0);
    step;
    chk("bp_a_in_m", out_pc1, 64'h100);
    ordy1 = 1'b0;
    put(1'b1, 32'h104, 5'd1, 1'b0, 5'd0);
    step;
    chk("bp_hold_a", out_pc1, 64'h100);
    chk("bp_busy", busy1, 1);
    chk("bp_rdy0", in_ready1, 0);
    put(1'b1, 32'h108, 5'd1, 1'b0, 5'd0);
    step;
    chk("bp_hold_a2", out_pc1, 64'h100);
    chk("bp_busy2", busy1, 1);
    ordy1 = 1'b1;
    step;
    chk("bp_b_out", out_pc1, 64'h104);
    chk("bp_busy_clr", busy1, 0);
    chk("bp_rdy1", in_ready1, 1);
    step;
    chk("bp_c_out", out_pc1, 64'h108);
    chk("bp_c_valid", out_valid1, 1);
    put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
    step;
    chk("bp_drained", out_valid1, 0);

    // flush with S full, then flush with an accepted beat
    put(1'b1, 32'h200, 5'd1, 1'b1, 5'd4);
    step;
    ordy1 = 1'b0;
    put(1'b1, 32'h204, 5'd1, 1'b1, 5'd5);
    step;
    chk("fl_busy_pre", busy1, 1);
    flush = 1'b1;
    put(1'b1, 32'h208, 5'd1, 1'b1, 5'd6);
    step;
    chk("fl_valid", out_valid1, 0);
    chk("fl_busy", busy1, 0);
    chk("fl_wa", out_wa1, 0);
    chk("fl_rdy", in_ready1, 1);
    ordy1 = 1'b1;
    put(1'b1, 32'h20C, 5'd1, 1'b1, 5'd7);
    step;
    chk("fl_fire_valid", out_valid1, 0);
    flush = 1'b0;
    put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
    step;
    chk("fl_never_out", out_valid1, 0);
    chk("fl_pc", out_pc1, 64'h3000);

    // SKID=0: combinational in_ready and hold under backpressure
    reset = 1'b1; step; reset = 1'b0;
    ordy0 = 1'b0;
    put(1'b1, 32'h400, 5'd1, 1'b0, 5'd0);
    step;
    chk("s0_g_valid", out_valid0, 1);
    chk("s0_g_pc", out_pc0, 64'h400);
    put(1'b1, 32'h404, 5'd5, 1'b1, 5'd9);
    #1;
    chk("s0_rdy_low", in_ready0, 0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk($sformatf("s0_hold%0d", k), out_pc0, 64'h400);
    end
    ordy0 = 1'b1;
    #1;
    chk("s0_rdy_high", in_ready0, 1);
    step;
    chk("s0_h_pc", out_pc0, 64'h404);
    chk("s0_h_tnew", out_tnew0, 4);
    chk("s0_h_instr", out_instr0, 64'hFFFF_FBFB);
    chk("s0_h_data", out_data0, 64'h0000_0404_FFFF_FBFB);
    chk("s0_h_wa", out_wa0, 9);
    chk("s0_h_we", out_we0, 1);
    put(1'b0, 32'h0, 5'd0, 1'b0, 5'd0);
    step;
    chk("s0_empty", out_valid0, 0);
    chk("s0_busy", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
